// File: rtl/cd_tx_frame_if.sv
// cd_tx_frame_if: byte stream from the TX frame sequencer to the UART serializer.
// Master drives data/valid; slave returns ready. A byte moves when tx_valid & tx_ready.
interface cd_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cd_tx_frame.sv
// cd_tx_frame: reads src/dst/len/payload from the TX frame RAM and streams it byte-by-byte.
// Optional CRC-16/MODBUS trailer (low byte first) is built in when CD_TX_CRC_EN is defined.
module cd_tx_frame #(
  parameter int MAX_LEN = 253
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          unread,
  output logic          rd_en,
  output logic [7:0]    rd_addr,
  input  logic [7:0]    rd_byte,
  output logic          rd_done,
  input  logic          tx_permit,
  cd_tx_frame_if.master tx,
  output logic          busy,
  output logic          tx_done,
  output logic          len_err
);

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    CRC_L = 3'd4,
    CRC_H = 3'd5,
    FIN   = 3'd6
  } state_e;

  state_e     state_q;
  logic       rd_en_q;
  logic [7:0] rd_addr_q;
  logic       rd_done_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       busy_q;
  logic       tx_done_q;
  logic       len_err_q;
  logic [7:0] len_q;

  logic hs_s;
  logic last_s;

  assign hs_s   = tx_valid_q & tx.tx_ready;
  // 9-bit compare so len+2 cannot wrap
  assign last_s = ({1'b0, rd_addr_q} == ({1'b0, len_q} + 9'd2));

`ifdef CD_TX_CRC_EN
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  assign crc_d = crc16_upd(crc_q, tx_data_q);
`endif

  // Frame sequencer: all outputs are registered and cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 8'd0;
      rd_done_q  <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      len_err_q  <= 1'b0;
      len_q      <= 8'd0;
`ifdef CD_TX_CRC_EN
      crc_q      <= 16'hFFFF;
`endif
    end else begin
      rd_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (unread && tx_permit) begin
            rd_addr_q <= 8'd0;
            len_q     <= 8'd0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
`ifdef CD_TX_CRC_EN
            crc_q     <= 16'hFFFF;
`endif
            state_q   <= FETCH;
          end else begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // Oversized length aborts before the length byte reaches the wire
          if ((rd_addr_q == 8'd2) && (rd_byte > MaxLenB)) begin
            rd_done_q <= 1'b1;
            len_err_q <= 1'b1;
            state_q   <= FIN;
          end else begin
            if (rd_addr_q == 8'd2) begin
              len_q <= rd_byte;
            end else begin
              len_q <= len_q;
            end
            tx_data_q  <= rd_byte;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (hs_s) begin
`ifdef CD_TX_CRC_EN
            crc_q <= crc_d;
`endif
            if (last_s) begin
`ifdef CD_TX_CRC_EN
              tx_data_q <= crc_d[7:0];
              state_q   <= CRC_L;
`else
              tx_valid_q <= 1'b0;
              rd_done_q  <= 1'b1;
              tx_done_q  <= 1'b1;
              state_q    <= FIN;
`endif
            end else begin
              tx_valid_q <= 1'b0;
              rd_addr_q  <= rd_addr_q + 8'd1;
              rd_en_q    <= 1'b1;
              state_q    <= FETCH;
            end
          end else begin
            state_q <= SEND;
          end
        end
`ifdef CD_TX_CRC_EN
        CRC_L: begin
          if (hs_s) begin
            tx_data_q <= crc_q[15:8];
            state_q   <= CRC_H;
          end else begin
            state_q <= CRC_L;
          end
        end
        CRC_H: begin
          if (hs_s) begin
            tx_valid_q <= 1'b0;
            rd_done_q  <= 1'b1;
            tx_done_q  <= 1'b1;
            state_q    <= FIN;
          end else begin
            state_q <= CRC_H;
          end
        end
`endif
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign rd_done     = rd_done_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign tx_done     = tx_done_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_cd_tx_frame.sv
// tb_cd_tx_frame: directed bench for cd_tx_frame with a behavioural frame RAM and a stream monitor.
// Works with and without CD_TX_CRC_EN defined.
module tb_cd_tx_frame;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       reset_n;
  logic       unread;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_byte;
  logic       rd_done;
  logic       tx_permit;
  logic       busy;
  logic       tx_done;
  logic       len_err;

  cd_tx_frame_if bus ();

  cd_tx_frame #(.MAX_LEN(253)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .unread    (unread),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_byte   (rd_byte),
    .rd_done   (rd_done),
    .tx_permit (tx_permit),
    .tx        (bus),
    .busy      (busy),
    .tx_done   (tx_done),
    .len_err   (len_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  byte_q_t    got_q;
  byte_q_t    exp_q;
  logic [7:0] addr_q[$];
  int         done_cnt  = 0;
  int         txd_cnt   = 0;
  int         lerr_cnt  = 0;
  int         stab_err  = 0;
  logic       hold      = 1'b0;
  logic [7:0] hold_data = 8'd0;
  bit         stall_mode  = 1'b0;
  int         stall_left  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_byte <= mem[rd_addr];
  end

  // Serializer ready: tied high or random 0-10 cycle stalls
  always @(negedge clk) begin
    if (!stall_mode) begin
      bus.tx_ready = 1'b1;
    end else if (stall_left > 0) begin
      bus.tx_ready = 1'b0;
      stall_left   = stall_left - 1;
    end else begin
      bus.tx_ready = 1'b1;
      stall_left   = int'($urandom_range(0, 10));
    end
  end

  // Stream and strobe monitor
  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (rd_en) addr_q.push_back(rd_addr);
      if (rd_done) done_cnt <= done_cnt + 1;
      if (tx_done) txd_cnt <= txd_cnt + 1;
      if (len_err) lerr_cnt <= lerr_cnt + 1;
      if (hold && !(bus.tx_valid && (bus.tx_data == hold_data))) stab_err <= stab_err + 1;
      hold      <= bus.tx_valid && !bus.tx_ready;
      hold_data <= bus.tx_data;
    end else begin
      hold <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input byte_q_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[k]) begin
      c = c ^ {8'h00, q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
`ifdef CD_TX_CRC_EN
    begin
      logic [15:0] c;
      c = crc_model(exp_q);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
`endif
  endtask

  task automatic cmp_stream(input string tag, input int start);
    int n;
    n = got_q.size() - start;
    check({tag, "_nbytes"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < n); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[start + i]), 32'(exp_q[i]));
  endtask

  task automatic load_std();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
  endtask

  // Starts a frame and waits (bounded) for rd_done; returns at the rd_done cycle
  task automatic run_frame(input string tag);
    bit ok;
    ok = 1'b0;
    unread    = 1'b1;
    tx_permit = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy) unread = 1'b0;
      if (rd_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},    32'(rd_en),        32'd0);
    check({tag, "_rd_addr"},  32'(rd_addr),      32'd0);
    check({tag, "_rd_done"},  32'(rd_done),      32'd0);
    check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_tx_done"},  32'(tx_done),      32'd0);
    check({tag, "_len_err"},  32'(len_err),      32'd0);
  endtask

  initial begin
    int g0, a0, d0, t0, l0, vcnt, maxa;
    byte_q_t ref_q;
    bit ok;

    reset_n   = 1'b1;
    unread    = 1'b0;
    tx_permit = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // CRC model sanity against the published MODBUS check value
    for (int i = 0; i < 9; i++) ref_q.push_back(8'h31 + 8'(i));
    check("crc_model_check", 32'(crc_model(ref_q)), 32'h0000_4B37);

    #1 reset_n = 1'b0;
    #2 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic frame, ready tied high
    load_std();
    build_exp(6);
    g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cnt; t0 = txd_cnt; l0 = lerr_cnt;
    run_frame("basic");
    check("basic_tx_done_with_rd_done", 32'(tx_done), 32'd1);
    check("basic_busy_on_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("basic_busy_after", 32'(busy), 32'd0);
    cmp_stream("basic", g0);
    check("basic_rd_en_count", 32'(addr_q.size() - a0), 32'd6);
    for (int k = 0; (k < 6) && (a0 + k < addr_q.size()); k++)
      check($sformatf("basic_addr%0d", k), 32'(addr_q[a0 + k]), 32'(k));
    check("basic_rd_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("basic_tx_done_cnt", 32'(txd_cnt - t0), 32'd1);
    check("basic_len_err_cnt", 32'(lerr_cnt - l0), 32'd0);
    @(negedge clk);

    // 2: same frame with random ready stalls
    stall_mode = 1'b1;
    g0 = got_q.size(); a0 = addr_q.size(); t0 = txd_cnt;
    run_frame("stall");
    @(negedge clk);
    stall_mode = 1'b0;
    cmp_stream("stall", g0);
    check("stall_rd_en_count", 32'(addr_q.size() - a0), 32'd6);
    check("stall_tx_done_cnt", 32'(txd_cnt - t0), 32'd1);
    check("stall_data_stable", 32'(stab_err), 32'd0);
    @(negedge clk);

    // 3: length byte above MAX_LEN
    mem[2] = 8'hFE;
    g0 = got_q.size(); a0 = addr_q.size(); t0 = txd_cnt; l0 = lerr_cnt;
    run_frame("lenerr");
    check("lenerr_pulse", 32'(len_err), 32'd1);
    check("lenerr_no_tx_done", 32'(tx_done), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tx_valid) vcnt++;
    end
    check("lenerr_nbytes", 32'(got_q.size() - g0), 32'd2);
    if (got_q.size() - g0 >= 2) begin
      check("lenerr_b0", 32'(got_q[g0]), 32'h01);
      check("lenerr_b1", 32'(got_q[g0 + 1]), 32'h02);
    end
    check("lenerr_rd_en_count", 32'(addr_q.size() - a0), 32'd3);
    check("lenerr_len_err_cnt", 32'(lerr_cnt - l0), 32'd1);
    check("lenerr_tx_done_cnt", 32'(txd_cnt - t0), 32'd0);
    check("lenerr_no_valid_after", 32'(vcnt), 32'd0);

    // 4: len = 0
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h00;
    build_exp(3);
    g0 = got_q.size(); a0 = addr_q.size();
    run_frame("len0");
    check("len0_tx_done", 32'(tx_done), 32'd1);
    @(negedge clk);
    cmp_stream("len0", g0);
    maxa = 0;
    for (int k = a0; k < addr_q.size(); k++) if (int'(addr_q[k]) > maxa) maxa = int'(addr_q[k]);
    check("len0_max_addr", 32'(maxa), 32'd2);
    check("len0_rd_en_count", 32'(addr_q.size() - a0), 32'd3);

    // 5: len = MAX_LEN is still legal and fills the address space
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[2] = 8'd253;
    build_exp(256);
    g0 = got_q.size(); a0 = addr_q.size(); l0 = lerr_cnt;
    run_frame("maxlen");
    check("maxlen_tx_done", 32'(tx_done), 32'd1);
    @(negedge clk);
    cmp_stream("maxlen", g0);
    check("maxlen_rd_en_count", 32'(addr_q.size() - a0), 32'd256);
    check("maxlen_no_len_err", 32'(lerr_cnt - l0), 32'd0);

    // 6: unread without permit, then permit, then permit dropped mid-frame
    load_std();
    build_exp(6);
    g0 = got_q.size(); a0 = addr_q.size(); t0 = txd_cnt;
    unread    = 1'b1;
    tx_permit = 1'b0;
    for (int i = 0; i < 50; i++) @(negedge clk);
    check("permit_wait_no_rd_en", 32'(addr_q.size() - a0), 32'd0);
    check("permit_wait_not_busy", 32'(busy), 32'd0);
    tx_permit = 1'b1;
    @(negedge clk);
    check("permit_start_rd_en", 32'(rd_en), 32'd1);
    check("permit_start_addr", 32'(rd_addr), 32'd0);
    unread = 1'b0;
    @(negedge clk);
    tx_permit = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("permit_drop_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    cmp_stream("permit_drop", g0);
    check("permit_drop_tx_done_cnt", 32'(txd_cnt - t0), 32'd1);

    // 7: reset mid-payload, then the same frame is resent from address 0
    g0 = got_q.size(); d0 = done_cnt;
    unread    = 1'b1;
    tx_permit = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) unread = 1'b0;
      if (got_q.size() - g0 >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_payload", 32'(ok), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_no_rd_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cnt;
    run_frame("resend");
    @(negedge clk);
    cmp_stream("resend", g0);
    check("resend_rd_en_count", 32'(addr_q.size() - a0), 32'd6);
    if (addr_q.size() > a0) check("resend_first_addr", 32'(addr_q[a0]), 32'd0);
    check("resend_rd_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cd_tx_frame.md
Name: cd_tx_frame

Overview:
- Frame reader/sequencer directly downstream of the double-buffered TX frame RAM.
- When the RAM reports an unread frame and the bus arbiter permits, it reads header and payload byte-by-byte and presents them on a valid/ready byte stream to the UART bit serializer.
- Appends a CRC16, then pulses `rd_done` to release the RAM buffer.

Parameters:
- MAX_LEN, 253: largest legal payload length byte; header (3) + MAX_LEN must fit the 8-bit RAM address space.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- unread  input  1  TX RAM holds a complete frame in the current read buffer
- rd_en  output  1  RAM read strobe, active high; `rd_byte` valid the cycle after
- rd_addr  output  8  RAM byte address
- rd_byte  input  8  RAM read data
- rd_done  output  1  one-cycle pulse: buffer consumed, RAM may flip read side
- tx_permit  input  1  arbiter grant to start a frame (sampled only in IDLE)
- tx_data  output  8  byte to serializer
- tx_valid  output  1  `tx_data` valid
- tx_ready  input  1  serializer accepts byte when `tx_valid & tx_ready`
- busy  output  1  high from frame start until `rd_done` cycle inclusive
- tx_done  output  1  one-cycle pulse with `rd_done` on a normally sent frame
- len_err  output  1  one-cycle pulse with `rd_done` when the length byte exceeds MAX_LEN

Behaviour:
- Reset (async, `reset_n` low): all outputs 0, `rd_addr` = 0, CRC register = 0xFFFF, state IDLE.
- Clock and reset: single `clk`; reset is asynchronous and active-low on `reset_n`.
- Frame layout in RAM: addr 0 src, 1 dst, 2 len, 3..len+2 payload. Bytes sent = len+3, plus 2 CRC bytes.
- States: IDLE, FETCH, WAIT, SEND, CRC_L, CRC_H, FIN.
- IDLE:
  - If `unread & tx_permit`: `rd_addr` <= 0, `busy` <= 1, CRC <= 0xFFFF, go to FETCH.
  - Otherwise stay in IDLE; `tx_permit` without `unread` is ignored.
- FETCH: assert `rd_en` for exactly one cycle at `rd_addr`, go to WAIT.
- WAIT: capture `rd_byte` into `tx_data`, assert `tx_valid`, go to SEND.
  - If `rd_addr` == 2, also latch len.
  - If len > MAX_LEN: do not assert `tx_valid`; go to FIN with the error flag set. Bytes 0 and 1 have already been sent; the serializer is expected to abort the frame on `len_err`.
- SEND: hold `tx_data`/`tx_valid` stable until `tx_ready`. On handshake:
  - `tx_valid` <= 0; CRC updated with `tx_data`.
  - If `rd_addr` == len+2: go to CRC_L.
  - Else: `rd_addr` +1, go to FETCH.
- Throughput: minimum 3 cycles per byte (FETCH, WAIT, SEND with `tx_ready` high); `tx_valid` drops for 2 cycles between bytes.
- CRC_L: present CRC[7:0], valid until handshake, then go to CRC_H.
- CRC_H: present CRC[15:8], valid until handshake, then go to FIN.
- FIN: pulse `rd_done` for 1 cycle, together with `tx_done` or `len_err`; `busy` <= 0; go to IDLE.
  - `unread` may still be high next cycle (other buffer full); the next frame needs a fresh IDLE check, so there is a minimum 1 idle cycle between frames.
- CRC: CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF, no final xor). Updated over all header and payload bytes in one cycle at handshake (8 unrolled iterations). Sent low byte first.
- `tx_permit` deasserting mid-frame is ignored; the frame always completes.
- `unread` is not rechecked after IDLE.
- len = 0 is legal: 3 header bytes + CRC.
- Reset mid-frame: state returns to IDLE immediately; no `rd_done` is issued, so the buffer remains unread in RAM (RAM shares `reset_n`).

Optional Feature:
- CD_TX_CRC_EN
  - Defined: CRC_L/CRC_H states and CRC logic present, as described above.
  - Undefined: no CRC logic; after the last payload handshake go directly to FIN; frame = len+3 bytes on the wire.

Test Plan:
- RAM frame 01 02 03 AA BB CC, `tx_permit` = 1, `tx_ready` tied 1 → tx stream 01 02 03 AA BB CC crc_lo crc_hi. CRC equals the MODBUS software model; `rd_done` and `tx_done` pulse once; `busy` falls the cycle after; `rd_en` issued 6 times, addr 0..5.
- `tx_ready` stalls randomly 0–10 cycles → `tx_data` stable while `tx_valid` and not ready; byte sequence identical to the previous scenario; no extra `rd_en`.
- len byte = 0xFE (> 253) → bytes 01 02 sent; `len_err` + `rd_done` pulse; no `tx_done`; no further `tx_valid`.
- len = 0 frame 10 20 00 → 5 bytes on the wire (3 without CD_TX_CRC_EN); `rd_addr` never exceeds 2.
- `unread` = 1, `tx_permit` = 0 for 50 cycles, then 1 → no `rd_en` during the wait; frame starts 1 cycle after permit. Dropping permit mid-frame does not stop transmission.
- Assert `reset_n` low mid-payload → all outputs 0 asynchronously; no `rd_done`. After release with permit, the same frame is resent from addr 0.
